lsu: RTL and testbench
======================

Name: lsu

Overview:
- Memory-stage load/store unit placed directly downstream of the pipelined core's M-stage outputs.
- Consumes the M-stage address (aluoutM), store data, access size and read/write strobes.
- Drives a single-outstanding request/grant/response data bus and returns the aligned, extended load result on readdataM.
- Raises stallM to freeze the pipeline while a bus access is in flight.

Parameters:
- ADDR_W, 32, address width of core and bus.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- memreadM  in  1  load request in M stage.
- memwriteM  in  1  store request in M stage.
- memsizeM  in  3  funct3 size code: [1:0] 00=byte, 01=half, 10=word, 11=illegal; [2]=1 selects zero-extend.
- aluoutM  in  32  byte address.
- writedataM  in  32  store data, right-aligned.
- readdataM  out  32  extended load result.
- stallM  out  1  hold the whole pipeline; M inputs stay stable while high.
- misalignM  out  1  one-cycle misaligned-access flag.
- bus_req  out  1  request valid.
- bus_we  out  1  write request.
- bus_addr  out  32  word-aligned address; [1:0] is always 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-positioned store data.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read response valid.
- bus_rdata  in  32  read response data.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Access present = memreadM | memwriteM. If both strobes are 1, the write wins and the read is ignored.
- FSM states: IDLE, REQ, WAIT, REQ2, WAIT2, DONE.
- IDLE
  - With an access present: stallM=1, compute lanes/byte enables, register bus fields, go to REQ.
  - Otherwise stay in IDLE with stallM=0.
- REQ
  - bus_req=1; all bus fields held stable until bus_gnt.
  - On gnt: a write goes to DONE, or to REQ2 if the access is split; a read goes to WAIT.
- WAIT
  - On bus_rvalid: capture the lanes selected by bus_be, then go to DONE, or to REQ2 if split.
  - bus_rvalid is ignored in every state except WAIT and WAIT2.
- REQ2 / WAIT2: same rules as REQ / WAIT, using the second word; both exit to DONE.
- DONE
  - stallM=0 for exactly one cycle, so the pipeline advances; readdataM is updated at entry.
  - Always returns to IDLE; the completed access is never reissued.
- stallM=1 in IDLE when an access is present, and in REQ, WAIT, REQ2 and WAIT2.
- Minimum load latency, with gnt in the first REQ cycle and rvalid one cycle later: 3 stall cycles.
- Minimum store latency: 2 stall cycles.
- Store lanes:
  - byte: data replicated ×4, be = 1<<addr[1:0].
  - half: data replicated ×2, be = 0011 or 1100.
  - word: be = 1111.
- Load extract: select the addressed byte or half; sign-extend unless memsizeM[2]=1.
- readdataM is registered and holds its value until the next load completes. Stores, illegal accesses and misaligned-abort accesses leave it unchanged.
- Illegal size (memsizeM[1:0]=11): no bus access; IDLE→DONE directly; misalignM=0.
- Misaligned access: word with addr[1:0]≠0, or half with addr[0]=1. Handling is selected by the optional feature below.
- Reset asserted mid-operation: FSM goes to IDLE and bus_req deasserts immediately (asynchronously). Any later rvalid is ignored.

Optional Feature:
- LSU_MISALIGN_SPLIT_EN
- Defined:
  - A misaligned access becomes two bus transactions: the first at addr&~3 with the upper lanes enabled, the second at (addr&~3)+4 with the remaining lower lanes.
  - Load bytes are merged in address order and then extended.
  - misalignM stays 0.
- Undefined:
  - A misaligned access performs no bus transaction; the FSM goes IDLE→DONE.
  - misalignM=1 during the DONE cycle; readdataM is unchanged.
  - REQ2 and WAIT2 are not synthesised.

Decomposition:
- Package lsu_pkg holds:
  - size encodings: SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
  - the zero-extend bit index;
  - the FSM state enum;
  - a be_t 4-bit typedef.
- One combinational sub-module, lsu_align: store lane positioning plus byte-enable generation, and load lane extraction/merge with sign/zero extension.
- The FSM and registers stay in lsu.

Test Plan:
- Aligned lw: addr 0x100, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF → bus_addr 0x100, be 1111; stallM high for 3 cycles; readdataM=0xDEADBEEF in DONE.
- lb vs lbu: addr 0x203, rdata 0x80FF_FF7F → lb gives 0xFFFFFF80; lbu (memsizeM=100) gives 0x00000080; be=1000.
- sh at addr 0x102, data 0x1234ABCD, gnt delayed 4 cycles → bus_wdata 0xABCDABCD, be 1100, bus fields stable throughout wait; stallM falls the cycle after gnt.
- lw at addr 0x101, two cases:
  - With LSU_MISALIGN_SPLIT_EN, words 0x44332211 then 0x88776655 → requests to 0x100 (be 1110) then 0x104 (be 0001); readdataM=0x55443322.
  - Without the macro → no bus_req; misalignM pulses once; readdataM unchanged.
- Reset low during WAIT, then rvalid arrives → bus_req=0 at once; FSM in IDLE; readdataM=0; the stray rvalid is ignored.
- memreadM=memwriteM=1 and memsizeM=011 in separate accesses → the first issues a write only; the second completes with no bus_req and one DONE cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: size codes, byte-enable type and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int ZEXT_BIT = 2;

  typedef logic [3:0] be_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    REQ2,
    WAIT2,
    DONE
  } lsuState_e;

  function automatic be_t sizeMask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Single-outstanding request/grant/response data bus between the LSU and memory.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import lsu_pkg::*;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  be_t               bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store data positioning, byte enables for up to two words,
// and load extraction/merge with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [31:0] storeData,
  output logic [31:0] laneData,
  output be_t         beLo,
  output be_t         beHi,
  input  logic [31:0] wordLo,
  input  logic [31:0] wordHi,
  output logic [31:0] loadData
);

  logic [31:0] repl;
  logic [31:0] raw;
  logic [7:0]  mask8;
  logic [4:0]  sh;

  always_comb begin
    sh = {addrLo, 3'b000};

    case (size)
      SZ_B:    repl = {4{storeData[7:0]}};
      SZ_H:    repl = {2{storeData[15:0]}};
      default: repl = storeData;
    endcase
    // Rotating the replicated pattern serves both words of a split store.
    laneData = 32'({repl, repl} >> (6'd32 - {1'b0, sh}));

    mask8 = {4'b0000, sizeMask(size)} << addrLo;
    beLo  = mask8[3:0];
    beHi  = mask8[7:4];

    raw = 32'({wordHi, wordLo} >> sh);
    case (size)
      SZ_B:    loadData = zext ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_H:    loadData = zext ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: loadData = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit: sequences one bus access per M-stage load/store and stalls the pipe.
// LSU_MISALIGN_SPLIT_EN: when defined, misaligned accesses become two bus words instead of aborting.
//
// state | meaning
// IDLE  | no access in flight; latch bus fields when an access appears
// REQ   | first word requested, waiting for grant
// WAIT  | first read word outstanding
// REQ2  | second word of a split access requested
// WAIT2 | second read word outstanding
// DONE  | one unstalled cycle so the pipeline advances
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic [2:0]        memsizeM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  output logic [DATA_W-1:0] readdataM,
  output logic              stallM,
  output logic              misalignM,
  lsu_if.master             bus
);

  lsuState_e state, stateNxt;

  logic [ADDR_W-1:0] busAddr;
  be_t               busBe;
  logic [DATA_W-1:0] busWdata;
  logic              busWe;
  logic              busReq;

  logic        access, illegal, abort, splitR;
  logic        loadDone, toSecond;
  logic [1:0]  size;
  logic [31:0] laneData, loadData, wordLo, wordHi;
  be_t         beLo, beHi;

  assign size    = memsizeM[1:0];
  assign access  = memreadM | memwriteM;
  assign illegal = (size == 2'b11);

  lsu_align uAlign (
    .addrLo   (aluoutM[1:0]),
    .size     (size),
    .zext     (memsizeM[ZEXT_BIT]),
    .storeData(writedataM),
    .laneData (laneData),
    .beLo     (beLo),
    .beHi     (beHi),
    .wordLo   (wordLo),
    .wordHi   (wordHi),
    .loadData (loadData)
  );

`ifdef LSU_MISALIGN_SPLIT_EN
  be_t         beHiR;
  logic [31:0] loWordR;

  assign abort  = illegal;
  assign wordLo = (state == WAIT) ? bus.bus_rdata : loWordR;
  assign wordHi = bus.bus_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      splitR  <= 1'b0;
      beHiR   <= '0;
      loWordR <= '0;
    end else if (state == IDLE && access) begin
      splitR <= (|beHi) & ~illegal;
      beHiR  <= beHi;
    end else if (state == WAIT && bus.bus_rvalid) begin
      loWordR <= bus.bus_rdata;
    end
  end
`else
  logic misaligned;
  logic unusedBeHi;

  assign splitR     = 1'b0;
  assign misaligned = (size == SZ_W && aluoutM[1:0] != 2'b00) || (size == SZ_H && aluoutM[0]);
  assign abort      = illegal | misaligned;
  assign wordLo     = bus.bus_rdata;
  assign wordHi     = '0;
  assign unusedBeHi = ^beHi;
`endif

  always_comb begin
    stateNxt = state;
    stallM   = 1'b0;
    busReq   = 1'b0;
    loadDone = 1'b0;
    toSecond = 1'b0;
    case (state)
      IDLE: begin
        stallM = access;
        if (access) stateNxt = abort ? DONE : REQ;
      end
      REQ: begin
        stallM = 1'b1;
        busReq = 1'b1;
        if (bus.bus_gnt) begin
          if (busWe) begin
            stateNxt = splitR ? REQ2 : DONE;
            toSecond = splitR;
          end else begin
            stateNxt = WAIT;
          end
        end
      end
      WAIT: begin
        stallM = 1'b1;
        if (bus.bus_rvalid) begin
          stateNxt = splitR ? REQ2 : DONE;
          toSecond = splitR;
          loadDone = ~splitR;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      REQ2: begin
        stallM = 1'b1;
        busReq = 1'b1;
        if (bus.bus_gnt) stateNxt = busWe ? DONE : WAIT2;
      end
      WAIT2: begin
        stallM = 1'b1;
        if (bus.bus_rvalid) begin
          stateNxt = DONE;
          loadDone = 1'b1;
        end
      end
`endif
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    // Keep stall low while reset is asserted even if the core presents an access.
    stallM = stallM & reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busAddr   <= '0;
      busBe     <= '0;
      busWdata  <= '0;
      busWe     <= 1'b0;
      readdataM <= '0;
      misalignM <= 1'b0;
    end else begin
      state     <= stateNxt;
      misalignM <= 1'b0;
      if (state == IDLE && access) begin
        busAddr  <= {aluoutM[ADDR_W-1:2], 2'b00};
        busBe    <= beLo;
        busWdata <= laneData;
        busWe    <= memwriteM;
`ifndef LSU_MISALIGN_SPLIT_EN
        misalignM <= misaligned;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (toSecond) begin
        busAddr <= busAddr + ADDR_W'(4);
        busBe   <= beHiR;
      end
`endif
      if (loadDone) readdataM <= loadData;
    end
  end

  assign bus.bus_req   = busReq;
  assign bus.bus_we    = busWe;
  assign bus.bus_addr  = busAddr;
  assign bus.bus_be    = busBe;
  assign bus.bus_wdata = busWdata;

`ifndef LSU_MISALIGN_SPLIT_EN
  logic unusedToSecond;
  assign unusedToSecond = toSecond;
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a small bus responder plus hand-computed expected results.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memreadM = 1'b0;
  logic        memwriteM = 1'b0;
  logic [2:0]  memsizeM = 3'b000;
  logic [31:0] aluoutM = 32'h0;
  logic [31:0] writedataM = 32'h0;
  logic [31:0] readdataM;
  logic        stallM;
  logic        misalignM;

  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(32), .DATA_W(32)) busIf ();

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .memreadM  (memreadM),
    .memwriteM (memwriteM),
    .memsizeM  (memsizeM),
    .aluoutM   (aluoutM),
    .writedataM(writedataM),
    .readdataM (readdataM),
    .stallM    (stallM),
    .misalignM (misalignM),
    .bus       (busIf.master)
  );

  int nTotal = 0;
  int nBad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTotal++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  int          nStall, nReq;
  bit          unstable, timedOut;
  logic [31:0] reqAddr[2];
  logic [3:0]  reqBe[2];
  logic        reqWe[2];
  logic [31:0] reqWdata[2];
  logic [31:0] doneRd;
  logic        doneMis, afterMis;

  // Runs one cycle per iteration until stallM drops (the DONE cycle), grants after gntDelay
  // wait cycles and answers reads one cycle after grant.
  task automatic serve(input int gntDelay, input logic [31:0] rd0, input logic [31:0] rd1);
    int   wcnt = 0;
    int   beat = 0;
    bit   pendR = 0;
    bit   snapValid = 0;
    logic [68:0] snap = '0;
    nStall = 0; nReq = 0; unstable = 0; timedOut = 1;
    for (int c = 0; c < 60; c++) begin
      busIf.bus_gnt = 1'b0;
      busIf.bus_rvalid = 1'b0;
      if (!stallM) begin
        timedOut = 0;
        break;
      end
      nStall++;
      if (pendR) begin
        busIf.bus_rvalid = 1'b1;
        busIf.bus_rdata = (beat == 0) ? rd0 : rd1;
        beat++;
        pendR = 0;
      end else if (busIf.bus_req) begin
        if (!snapValid) begin
          snap = {busIf.bus_we, busIf.bus_be, busIf.bus_addr, busIf.bus_wdata};
          snapValid = 1;
        end else if (snap !== {busIf.bus_we, busIf.bus_be, busIf.bus_addr, busIf.bus_wdata}) begin
          unstable = 1;
        end
        if (wcnt == gntDelay) begin
          busIf.bus_gnt = 1'b1;
          if (nReq < 2) begin
            reqAddr[nReq] = busIf.bus_addr;
            reqBe[nReq] = busIf.bus_be;
            reqWe[nReq] = busIf.bus_we;
            reqWdata[nReq] = busIf.bus_wdata;
          end
          nReq++;
          wcnt = 0;
          pendR = !busIf.bus_we;
          snapValid = 0;
        end else begin
          wcnt++;
        end
      end
      @(negedge clk);
      #1;
    end
    busIf.bus_gnt = 1'b0;
    busIf.bus_rvalid = 1'b0;
  endtask

  task automatic runAcc(input logic rd, input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input int gntDelay, input logic [31:0] rd0,
                        input logic [31:0] rd1);
    @(negedge clk);
    memreadM = rd; memwriteM = wr; memsizeM = sz; aluoutM = addr; writedataM = wd;
    #1;
    serve(gntDelay, rd0, rd1);
    chk("timeout", 32'(timedOut), 32'h0);
    doneRd = readdataM;
    doneMis = misalignM;
    memreadM = 1'b0;
    memwriteM = 1'b0;
    @(negedge clk);
    #1;
    afterMis = misalignM;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    busIf.bus_gnt = 1'b0;
    busIf.bus_rvalid = 1'b0;
    busIf.bus_rdata = 32'h0;
    memreadM = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stallM), 32'h0);
    chk("rst_req", 32'(busIf.bus_req), 32'h0);
    chk("rst_addr", busIf.bus_addr, 32'h0);
    chk("rst_be", 32'(busIf.bus_be), 32'h0);
    chk("rst_rd", readdataM, 32'h0);
    chk("rst_mis", 32'(misalignM), 32'h0);
    memreadM = 1'b0;
    reset = 1'b1;

    runAcc(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'h0);
    chk("lw_stall", 32'(nStall), 32'd3);
    chk("lw_nreq", 32'(nReq), 32'd1);
    chk("lw_addr", reqAddr[0], 32'h100);
    chk("lw_be", 32'(reqBe[0]), 32'hF);
    chk("lw_we", 32'(reqWe[0]), 32'h0);
    chk("lw_rd", doneRd, 32'hDEADBEEF);

    runAcc(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FFFF7F, 32'h0);
    chk("lb_addr", reqAddr[0], 32'h200);
    chk("lb_be", 32'(reqBe[0]), 32'h8);
    chk("lb_rd", doneRd, 32'hFFFFFF80);

    runAcc(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80FFFF7F, 32'h0);
    chk("lbu_rd", doneRd, 32'h00000080);
    chk("lbu_stall", 32'(nStall), 32'd3);

    runAcc(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 4, 32'h0, 32'h0);
    chk("sh_wdata", reqWdata[0], 32'hABCDABCD);
    chk("sh_be", 32'(reqBe[0]), 32'hC);
    chk("sh_addr", reqAddr[0], 32'h100);
    chk("sh_we", 32'(reqWe[0]), 32'h1);
    chk("sh_stable", 32'(unstable), 32'h0);
    chk("sh_stall", 32'(nStall), 32'd6);
    chk("sh_rd_keep", doneRd, 32'h00000080);

    runAcc(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80017777, 32'h0);
    chk("lh_be", 32'(reqBe[0]), 32'hC);
    chk("lh_rd", doneRd, 32'hFFFF8001);

    runAcc(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 0, 32'h0, 32'h0);
    chk("sb_wdata", reqWdata[0], 32'hA5A5A5A5);
    chk("sb_be", 32'(reqBe[0]), 32'h2);
    chk("sb_stall", 32'(nStall), 32'd2);

    runAcc(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h44332211, 32'h88776655);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("mis_nreq", 32'(nReq), 32'd2);
    chk("mis_addr0", reqAddr[0], 32'h100);
    chk("mis_be0", 32'(reqBe[0]), 32'hE);
    chk("mis_addr1", reqAddr[1], 32'h104);
    chk("mis_be1", 32'(reqBe[1]), 32'h1);
    chk("mis_stall", 32'(nStall), 32'd5);
    chk("mis_flag", 32'(doneMis), 32'h0);
    chk("mis_rd", doneRd, 32'h55443322);
`else
    chk("mis_nreq", 32'(nReq), 32'd0);
    chk("mis_stall", 32'(nStall), 32'd1);
    chk("mis_flag", 32'(doneMis), 32'h1);
    chk("mis_flag_off", 32'(afterMis), 32'h0);
    chk("mis_rd", doneRd, 32'hFFFF8001);
`endif

    runAcc(1'b1, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h11111111, 32'h0);
    chk("both_nreq", 32'(nReq), 32'd1);
    chk("both_we", 32'(reqWe[0]), 32'h1);
    chk("both_wdata", reqWdata[0], 32'hCAFEF00D);
    chk("both_stall", 32'(nStall), 32'd2);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("both_rd_keep", doneRd, 32'h55443322);
`else
    chk("both_rd_keep", doneRd, 32'hFFFF8001);
`endif

    runAcc(1'b1, 1'b0, 3'b011, 32'h400, 32'h0, 0, 32'h22222222, 32'h0);
    chk("ill_nreq", 32'(nReq), 32'd0);
    chk("ill_stall", 32'(nStall), 32'd1);
    chk("ill_mis", 32'(doneMis), 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("ill_rd_keep", doneRd, 32'h55443322);
`else
    chk("ill_rd_keep", doneRd, 32'hFFFF8001);
`endif

    // Reset while a read is outstanding.
    @(negedge clk);
    memreadM = 1'b1; memsizeM = 3'b010; aluoutM = 32'h500;
    @(negedge clk);
    #1;
    chk("rs_req", 32'(busIf.bus_req), 32'h1);
    busIf.bus_gnt = 1'b1;
    @(negedge clk);
    #1;
    busIf.bus_gnt = 1'b0;
    chk("rs_wait", 32'(dut.state), 32'(WAIT));
    reset = 1'b0;
    #1;
    chk("rs_req_off", 32'(busIf.bus_req), 32'h0);
    chk("rs_idle", 32'(dut.state), 32'(IDLE));
    chk("rs_rd", readdataM, 32'h0);
    memreadM = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    busIf.bus_rvalid = 1'b1;
    busIf.bus_rdata = 32'h12345678;
    @(negedge clk);
    #1;
    busIf.bus_rvalid = 1'b0;
    chk("rs_stray_rd", readdataM, 32'h0);
    chk("rs_stray_idle", 32'(dut.state), 32'(IDLE));
    chk("rs_stray_stall", 32'(stallM), 32'h0);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
